// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_stage : RV64 memory-access stage (lane steering, load extension)      |
// | Revision  : 1.0                                                           |
// +----------------------------------------------------------------------------+
module mem_stage #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regM_i_valid,
  output logic              regM_o_ready,
  input  logic              regM_i_flush,
  input  logic              regM_i_load,
  input  logic              regM_i_store,
  input  logic [2:0]        regM_i_funct3,
  input  logic [XLEN-1:0]   regM_i_alu_result,
  input  logic [XLEN-1:0]   regM_i_reg_rdata2,
  input  logic [4:0]        regM_i_rd,
  input  logic              regM_i_wen,
  output logic              dmem_o_valid,
  input  logic              dmem_i_ready,
  output logic [ADDR_W-1:0] dmem_o_addr,
  output logic              dmem_o_we,
  output logic [XLEN-1:0]   dmem_o_wdata,
  output logic [7:0]        dmem_o_wstrb,
  input  logic              dmem_i_rvalid,
  input  logic [XLEN-1:0]   dmem_i_rdata,
  output logic              regW_o_valid,
  output logic [4:0]        regW_o_rd,
  output logic              regW_o_wen,
  output logic [XLEN-1:0]   regW_o_wdata,
  output logic              regW_o_exc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e     state_q;
  logic       store_q;
  logic [2:0] funct3_q;
  logic [2:0] offset_q;
  logic [4:0] rd_q;
  logic       wen_q;
  logic       kill_q;

  logic              w_accept;
  logic              w_is_mem;
  logic              w_illegal;
  logic              w_misalign;
  logic [2:0]        w_off;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_wstrb;
  logic [XLEN-1:0]   w_shifted;
  logic [XLEN-1:0]   w_load_ext;
  logic              w_kill_now;

  assign regM_o_ready = (state_q == IDLE) & ~regM_i_flush;
  assign w_accept     = regM_i_valid & regM_o_ready;
  assign w_is_mem     = regM_i_load | regM_i_store;
  assign w_addr       = regM_i_alu_result[ADDR_W-1:0];
  assign w_off        = regM_i_alu_result[2:0];
  assign w_kill_now   = kill_q | regM_i_flush;

  // A request carrying both load and store is treated like a bad size.
  always_comb begin
    w_illegal = (regM_i_load & regM_i_store)
              | (regM_i_load & (regM_i_funct3 == 3'b111))
              | (regM_i_store & regM_i_funct3[2]);
    w_misalign = 1'b0;
    w_wstrb    = 8'h00;
    case (regM_i_funct3[1:0])
      2'b00: begin
        w_misalign = 1'b0;
        w_wstrb    = 8'h01 << w_off;
      end
      2'b01: begin
        w_misalign = w_off[0];
        w_wstrb    = 8'h03 << w_off;
      end
      2'b10: begin
        w_misalign = (w_off[1:0] != 2'b00);
        w_wstrb    = 8'h0F << w_off;
      end
      default: begin
        w_misalign = (w_off != 3'b000);
        w_wstrb    = 8'hFF;
      end
    endcase
  end

  assign w_shifted = dmem_i_rdata >> {offset_q, 3'b000};

  always_comb begin
    w_load_ext = w_shifted;
    case (funct3_q)
      3'b000:  w_load_ext = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
      3'b001:  w_load_ext = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_load_ext = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
      3'b100:  w_load_ext = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
      3'b101:  w_load_ext = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      3'b110:  w_load_ext = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
      default: w_load_ext = w_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      funct3_q     <= 3'b000;
      offset_q     <= 3'b000;
      rd_q         <= 5'd0;
      wen_q        <= 1'b0;
      kill_q       <= 1'b0;
      dmem_o_valid <= 1'b0;
      dmem_o_addr  <= '0;
      dmem_o_we    <= 1'b0;
      dmem_o_wdata <= '0;
      dmem_o_wstrb <= 8'h00;
      regW_o_valid <= 1'b0;
      regW_o_rd    <= 5'd0;
      regW_o_wen   <= 1'b0;
      regW_o_wdata <= '0;
      regW_o_exc   <= 1'b0;
    end else begin
      regW_o_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_accept) begin
            if (!w_is_mem) begin
              regW_o_valid <= 1'b1;
              regW_o_rd    <= regM_i_rd;
              regW_o_wen   <= regM_i_wen & (regM_i_rd != 5'd0);
              regW_o_wdata <= regM_i_alu_result;
              regW_o_exc   <= 1'b0;
            end else if (w_illegal || w_misalign) begin
              regW_o_valid <= 1'b1;
              regW_o_rd    <= regM_i_rd;
              regW_o_wen   <= 1'b0;
              regW_o_wdata <= regM_i_alu_result;
              regW_o_exc   <= 1'b1;
            end else begin
              state_q      <= REQ;
              store_q      <= regM_i_store;
              funct3_q     <= regM_i_funct3;
              offset_q     <= w_off;
              rd_q         <= regM_i_rd;
              wen_q        <= regM_i_wen;
              kill_q       <= 1'b0;
              dmem_o_valid <= 1'b1;
              dmem_o_addr  <= {w_addr[ADDR_W-1:3], 3'b000};
              dmem_o_we    <= regM_i_store;
              dmem_o_wdata <= regM_i_reg_rdata2 << {w_off, 3'b000};
              dmem_o_wstrb <= w_wstrb;
            end
          end
        end
        REQ: begin
          if (regM_i_flush) kill_q <= 1'b1;
          if (dmem_i_ready) begin
            dmem_o_valid <= 1'b0;
            if (store_q) begin
              state_q      <= IDLE;
              regW_o_valid <= ~w_kill_now;
              regW_o_rd    <= rd_q;
              regW_o_wen   <= 1'b0;
              regW_o_wdata <= '0;
              regW_o_exc   <= 1'b0;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (regM_i_flush) kill_q <= 1'b1;
          if (dmem_i_rvalid) begin
            state_q      <= IDLE;
            regW_o_valid <= ~w_kill_now;
            regW_o_rd    <= rd_q;
            regW_o_wen   <= wen_q & (rd_q != 5'd0);
            regW_o_wdata <= w_load_ext;
            regW_o_exc   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// Directed bench for mem_stage: scoreboard of expected writeback records plus
// bus-side checks made by the stimulus tasks.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        regM_i_valid, regM_o_ready, regM_i_flush, regM_i_load, regM_i_store;
  logic [2:0]  regM_i_funct3;
  logic [63:0] regM_i_alu_result, regM_i_reg_rdata2;
  logic [4:0]  regM_i_rd;
  logic        regM_i_wen;
  logic        dmem_o_valid, dmem_i_ready, dmem_o_we, dmem_i_rvalid;
  logic [63:0] dmem_o_addr, dmem_o_wdata, dmem_i_rdata;
  logic [7:0]  dmem_o_wstrb;
  logic        regW_o_valid, regW_o_wen, regW_o_exc;
  logic [4:0]  regW_o_rd;
  logic [63:0] regW_o_wdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          chk_data;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] wdata;
    logic        exc;
  } rec_t;
  rec_t exp_q[$];

  mem_stage #(.XLEN(64), .ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .regM_i_valid(regM_i_valid), .regM_o_ready(regM_o_ready),
    .regM_i_flush(regM_i_flush), .regM_i_load(regM_i_load),
    .regM_i_store(regM_i_store), .regM_i_funct3(regM_i_funct3),
    .regM_i_alu_result(regM_i_alu_result), .regM_i_reg_rdata2(regM_i_reg_rdata2),
    .regM_i_rd(regM_i_rd), .regM_i_wen(regM_i_wen),
    .dmem_o_valid(dmem_o_valid), .dmem_i_ready(dmem_i_ready),
    .dmem_o_addr(dmem_o_addr), .dmem_o_we(dmem_o_we),
    .dmem_o_wdata(dmem_o_wdata), .dmem_o_wstrb(dmem_o_wstrb),
    .dmem_i_rvalid(dmem_i_rvalid), .dmem_i_rdata(dmem_i_rdata),
    .regW_o_valid(regW_o_valid), .regW_o_rd(regW_o_rd),
    .regW_o_wen(regW_o_wen), .regW_o_wdata(regW_o_wdata),
    .regW_o_exc(regW_o_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic push(input bit cd, input logic [4:0] rd, input logic wen,
                      input logic [63:0] wd, input logic exc);
    rec_t r;
    r.chk_data = cd; r.rd = rd; r.wen = wen; r.wdata = wd; r.exc = exc;
    exp_q.push_back(r);
  endtask

  // Monitor: every record the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && regW_o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_record: got rd=%0d wdata=0x%h expected none",
                 regW_o_rd, regW_o_wdata);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        chk("rec_wen", {63'd0, regW_o_wen}, {63'd0, e.wen});
        chk("rec_exc", {63'd0, regW_o_exc}, {63'd0, e.exc});
        if (e.chk_data) begin
          chk("rec_wdata", regW_o_wdata, e.wdata);
          chk("rec_rd", {59'd0, regW_o_rd}, {59'd0, e.rd});
        end
      end
    end
  end

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] d,
                       input logic [4:0] rd, input logic wen);
    regM_i_valid = 1'b1; regM_i_load = ld; regM_i_store = st;
    regM_i_funct3 = f3; regM_i_alu_result = a; regM_i_reg_rdata2 = d;
    regM_i_rd = rd; regM_i_wen = wen;
  endtask

  task automatic idle_in();
    regM_i_valid = 1'b0; regM_i_load = 1'b0; regM_i_store = 1'b0;
  endtask

  // Load: accept, hold off ready for rdly cycles, then rvalid after wdly cycles.
  task automatic do_load(input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] rdata, input int rdly, input int wdly,
                         input logic [4:0] rd, input logic wen,
                         input logic exp_wen, input logic [63:0] exp, input bit flush_wait);
    if (!flush_wait) push(1'b1, rd, exp_wen, exp, 1'b0);
    drive(1'b1, 1'b0, f3, a, 64'hDEAD_0000_DEAD_0000, rd, wen);
    @(negedge clk);
    idle_in();
    chk("ld_req_valid", {63'd0, dmem_o_valid}, 64'd1);
    chk("ld_req_addr", dmem_o_addr, {a[63:3], 3'b000});
    chk("ld_req_we", {63'd0, dmem_o_we}, 64'd0);
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      chk("ld_hold_valid", {63'd0, dmem_o_valid}, 64'd1);
    end
    dmem_i_ready = 1'b1;
    @(negedge clk);
    dmem_i_ready = 1'b0;
    chk("ld_valid_drop", {63'd0, dmem_o_valid}, 64'd0);
    for (int i = 0; i < wdly; i++) begin
      regM_i_flush = flush_wait && (i == 0);
      @(negedge clk);
    end
    regM_i_flush = 1'b0;
    dmem_i_rvalid = 1'b1;
    dmem_i_rdata = rdata;
    @(negedge clk);
    dmem_i_rvalid = 1'b0;
    dmem_i_rdata = 64'd0;
    chk("ld_record_timing", {63'd0, regW_o_valid}, {63'd0, !flush_wait});
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] d, input int rdly,
                          input logic [63:0] exp_wdata, input logic [7:0] exp_strb);
    push(1'b0, 5'd0, 1'b0, 64'd0, 1'b0);
    drive(1'b0, 1'b1, f3, a, d, 5'd9, 1'b1);
    @(negedge clk);
    idle_in();
    for (int i = 0; i <= rdly; i++) begin
      chk("st_valid", {63'd0, dmem_o_valid}, 64'd1);
      chk("st_addr", dmem_o_addr, {a[63:3], 3'b000});
      chk("st_we", {63'd0, dmem_o_we}, 64'd1);
      chk("st_wdata", dmem_o_wdata, exp_wdata);
      chk("st_wstrb", {56'd0, dmem_o_wstrb}, {56'd0, exp_strb});
      if (i < rdly) @(negedge clk);
    end
    dmem_i_ready = 1'b1;
    @(negedge clk);
    dmem_i_ready = 1'b0;
    chk("st_valid_drop", {63'd0, dmem_o_valid}, 64'd0);
    chk("st_record", {63'd0, regW_o_valid}, 64'd1);
  endtask

  task automatic do_exc(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] a);
    push(1'b1, 5'd7, 1'b0, a, 1'b1);
    drive(ld, st, f3, a, 64'h1111, 5'd7, 1'b1);
    @(negedge clk);
    idle_in();
    chk("exc_no_bus", {63'd0, dmem_o_valid}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; regM_i_flush = 1'b0; dmem_i_ready = 1'b0; dmem_i_rvalid = 1'b0;
    dmem_i_rdata = 64'd0; regM_i_funct3 = 3'd0; regM_i_alu_result = 64'd0;
    regM_i_reg_rdata2 = 64'd0; regM_i_rd = 5'd0; regM_i_wen = 1'b0;
    idle_in();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", {63'd0, regM_o_ready}, 64'd1);
    chk("rst_dmem_valid", {63'd0, dmem_o_valid}, 64'd0);
    chk("rst_regw_valid", {63'd0, regW_o_valid}, 64'd0);
    chk("rst_regw_wdata", regW_o_wdata, 64'd0);
    chk("rst_wstrb", {56'd0, dmem_o_wstrb}, 64'd0);

    // Back-to-back ALU results, one per cycle.
    push(1'b1, 5'd5, 1'b1, 64'h1234, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 64'h1234, 64'd0, 5'd5, 1'b1);
    @(negedge clk);
    chk("b2b_ready", {63'd0, regM_o_ready}, 64'd1);
    push(1'b1, 5'd0, 1'b0, 64'h5678, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 64'h5678, 64'd0, 5'd0, 1'b1);
    @(negedge clk);
    push(1'b1, 5'd31, 1'b0, 64'hABCD, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 64'hABCD, 64'd0, 5'd31, 1'b0);
    @(negedge clk);
    idle_in();
    @(negedge clk);

    // Loads with sign/zero extension and lane steering.
    do_load(3'b000, 64'h1003, 64'h0000_0000_8000_0000, 0, 0, 5'd3, 1'b1, 1'b1,
            64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    do_load(3'b100, 64'h1003, 64'h0000_0000_8000_0000, 0, 0, 5'd4, 1'b1, 1'b1,
            64'h0000_0000_0000_0080, 1'b0);
    do_load(3'b001, 64'h1006, 64'h8001_0000_0000_0000, 1, 1, 5'd6, 1'b1, 1'b1,
            64'hFFFF_FFFF_FFFF_8001, 1'b0);
    do_load(3'b010, 64'h1004, 64'hDEAD_BEEF_0000_0000, 0, 0, 5'd8, 1'b1, 1'b1,
            64'hFFFF_FFFF_DEAD_BEEF, 1'b0);
    do_load(3'b110, 64'h1004, 64'hDEAD_BEEF_0000_0000, 0, 0, 5'd8, 1'b1, 1'b1,
            64'h0000_0000_DEAD_BEEF, 1'b0);
    do_load(3'b011, 64'h3000, 64'h0123_4567_89AB_CDEF, 2, 2, 5'd10, 1'b1, 1'b1,
            64'h0123_4567_89AB_CDEF, 1'b0);
    do_load(3'b011, 64'h3000, 64'h0123_4567_89AB_CDEF, 0, 0, 5'd0, 1'b1, 1'b0,
            64'h0123_4567_89AB_CDEF, 1'b0);
    do_load(3'b011, 64'h3008, 64'h5555_5555_5555_5555, 0, 2, 5'd11, 1'b1, 1'b0,
            64'd0, 1'b1);
    @(negedge clk);

    // Stores with back-pressure.
    do_store(3'b001, 64'h2006, 64'hBEEF, 3, 64'hBEEF_0000_0000_0000, 8'hC0);
    do_store(3'b000, 64'h2005, 64'h11, 0, 64'h0000_1100_0000_0000, 8'h20);
    do_store(3'b011, 64'h2008, 64'hCAFE_F00D_1234_5678, 1, 64'hCAFE_F00D_1234_5678, 8'hFF);
    @(negedge clk);

    // Misaligned and illegal accesses.
    do_exc(1'b1, 1'b0, 3'b010, 64'h3002);
    do_exc(1'b1, 1'b0, 3'b001, 64'h3001);
    do_exc(1'b0, 1'b1, 3'b011, 64'h3004);
    do_exc(1'b1, 1'b0, 3'b111, 64'h3000);
    do_exc(1'b0, 1'b1, 3'b100, 64'h3000);
    do_exc(1'b1, 1'b1, 3'b011, 64'h3000);
    @(negedge clk);

    // Flush in IDLE blocks acceptance.
    drive(1'b0, 1'b0, 3'd0, 64'h9999, 64'd0, 5'd12, 1'b1);
    regM_i_flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_ready", {63'd0, regM_o_ready}, 64'd0);
    idle_in();
    regM_i_flush = 1'b0;
    @(negedge clk);

    // Reset while a request is outstanding.
    drive(1'b1, 1'b0, 3'b011, 64'h4000, 64'd0, 5'd13, 1'b1);
    @(negedge clk);
    idle_in();
    chk("rstreq_pre_valid", {63'd0, dmem_o_valid}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstreq_dmem_valid", {63'd0, dmem_o_valid}, 64'd0);
    chk("rstreq_ready", {63'd0, regM_o_ready}, 64'd1);
    repeat (4) @(negedge clk);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
